// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions: opcodes, slot timing, instruction field layout and fetch states.
package cpu_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ABS = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_NEG = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam int         SLOT_CYCLES = 8;
    localparam logic [2:0] SLOT_LAST   = 3'd7;

    // Instruction word layout: [7:5] opcode, [4:2] operand 1 address,
    // [1] operand 2 type, [0] operand number.
    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 5;
    localparam int OP1_MSB  = 4;
    localparam int OP1_LSB  = 2;
    localparam int OP2T_BIT = 1;
    localparam int OPN_BIT  = 0;

    // Idle instruction register value decodes as HLT.
    localparam logic [7:0] IR_RESET = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // True when the instruction word carries the HLT opcode.
    function automatic logic is_hlt(input logic [7:0] word);
        return (word[OPC_MSB:OPC_LSB] == OP_HLT);
    endfunction

endpackage : cpu_pkg

// File: rtl/instruction_fetch_unit_if.sv
// Load/start bus and decoded-instruction outputs of the fetch unit.
interface instruction_fetch_unit_if #(
    parameter int PC_W = 4
);
    logic            Load_enable;
    logic [PC_W-1:0] Load_address;
    logic [7:0]      Load_data;
    logic            Start;

    logic [2:0]      Opcode;
    logic [2:0]      Operand_1_address;
    logic            Operand_2_type;
    logic            Operand_number;
    logic [PC_W-1:0] PC_out;
    logic [2:0]      Slot;
    logic            Running;
    logic            Halted;

    // Host / testbench side: loads the program, requests runs, observes the fetch.
    modport master (
        output Load_enable, Load_address, Load_data, Start,
        input  Opcode, Operand_1_address, Operand_2_type, Operand_number,
        input  PC_out, Slot, Running, Halted
    );

    // Fetch unit side.
    modport slave (
        input  Load_enable, Load_address, Load_data, Start,
        output Opcode, Operand_1_address, Operand_2_type, Operand_number,
        output PC_out, Slot, Running, Halted
    );
endinterface : instruction_fetch_unit_if

// File: rtl/instruction_fetch_unit_memory.sv
// Program store: DEPTH x 8 array, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module instruction_memory #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [DEPTH];

    // Write port: one word per edge when enabled.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A read of the address being written this edge returns the old word.
    assign rdata_o = mem_q[raddr_i];
endmodule : instruction_memory

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program store, program counter and 8-phase slot
// counter; presents one instruction per slot to the downstream decoder.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    instruction_fetch_unit_if.slave  bus
);
    localparam logic [PC_W-1:0] PC_ZERO = PC_W'(0);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    fetch_state_e    state_q, state_d;
    logic [2:0]      slot_q;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            pending_q, pending_d;
    logic            running_q, running_d;
    logic            halted_q, halted_d;

    logic            boundary_s;
    logic            launch_s;
    logic            mem_we_s;
    logic [PC_W-1:0] fetch_addr_s;
    logic [7:0]      fetch_word_s;
    logic            fetch_hlt_s;

    // Slot 7 edge is where a new instruction is latched.
    assign boundary_s   = (slot_q == SLOT_LAST);
    // A run starts from IDLE/HALT at a boundary if a Start is pending or present now.
    assign launch_s     = boundary_s && (state_q != ST_RUN) && (pending_q || bus.Start);
    // Program store is writable only while not running.
    assign mem_we_s     = bus.Load_enable && (state_q != ST_RUN);
    // Restarts always fetch from address 0; running fetches follow the PC.
    assign fetch_addr_s = (state_q == ST_RUN) ? pc_q : PC_ZERO;
    assign fetch_hlt_s  = is_hlt(fetch_word_s);

    instruction_memory #(
        .DEPTH (DEPTH),
        .AW    (PC_W)
    ) u_mem (
        .CLK     (CLK),
        .we_i    (mem_we_s),
        .waddr_i (bus.Load_address),
        .wdata_i (bus.Load_data),
        .raddr_i (fetch_addr_s),
        .rdata_o (fetch_word_s)
    );

    // Free-running slot counter, cleared only by RESET so it tracks the decoder.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_q <= 3'd0;
        end else begin
            slot_q <= slot_q + 3'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (launch_s) begin
                    state_d = fetch_hlt_s ? ST_HALT : ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (boundary_s && fetch_hlt_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: PC, IR, pending-start flag and status next values.
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (launch_s) begin
                    ir_d      = fetch_word_s;
                    pc_d      = fetch_hlt_s ? PC_ZERO : PC_ONE;
                    pending_d = 1'b0;
                end else begin
                    pending_d = pending_q || bus.Start;
                end
            end
            ST_RUN: begin
                if (boundary_s) begin
                    ir_d = fetch_word_s;
                    pc_d = fetch_hlt_s ? pc_q : (pc_q + PC_ONE);
                end else begin
                    ir_d = ir_q;
                end
            end
            default: begin
                pc_d      = PC_ZERO;
                ir_d      = IR_RESET;
                pending_d = 1'b0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    // Datapath and status registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q      <= PC_ZERO;
            ir_q      <= IR_RESET;
            pending_q <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            pending_q <= pending_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.Opcode            = ir_q[OPC_MSB:OPC_LSB];
    assign bus.Operand_1_address = ir_q[OP1_MSB:OP1_LSB];
    assign bus.Operand_2_type    = ir_q[OP2T_BIT];
    assign bus.Operand_number    = ir_q[OPN_BIT];
    assign bus.PC_out            = pc_q;
    assign bus.Slot              = slot_q;
    assign bus.Running           = running_q;
    assign bus.Halted            = halted_q;
endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit (DEPTH=16 and DEPTH=4).
module tb_instruction_fetch_unit;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    instruction_fetch_unit_if #(.PC_W(4)) bus  ();
    instruction_fetch_unit_if #(.PC_W(2)) bus4 ();

    instruction_fetch_unit #(.DEPTH(16)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    instruction_fetch_unit #(.DEPTH(4)) u_dut4 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus4)
    );

    // 10 ns clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop if the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [2:0] a1;
        logic       o2t;
        logic       onum;
        logic [3:0] pc;
        logic       run;
        logic       halt;
        logic       ld_en;
        logic [3:0] ld_addr;
        logic [7:0] ld_data;
    } slot_vec_t;

    slot_vec_t  vecs [3];
    logic [1:0] wrap_pc [5];
    logic [2:0] wrap_a1 [5];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_slot(input logic [2:0] s);
        int n;
        n = 0;
        while (bus.Slot !== s && n < 16) begin
            tick();
            n++;
        end
        if (bus.Slot !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_slot: got %0h, expected %0h", bus.Slot, s);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        bus.Load_enable  = 1'b1;
        bus.Load_address = a;
        bus.Load_data    = d;
        tick();
        bus.Load_enable  = 1'b0;
    endtask

    task automatic load4(input logic [1:0] a, input logic [7:0] d);
        bus4.Load_enable  = 1'b1;
        bus4.Load_address = a;
        bus4.Load_data    = d;
        tick();
        bus4.Load_enable  = 1'b0;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic chk_status(input string nm, input logic [2:0] op, input logic [3:0] pc,
                              input logic run, input logic halt);
        chk({nm, "_opcode"},  bus.Opcode,  op);
        chk({nm, "_pc"},      bus.PC_out,  pc);
        chk({nm, "_running"}, bus.Running, run);
        chk({nm, "_halted"},  bus.Halted,  halt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b1;
        bus.Load_enable   = 1'b0;
        bus.Load_address  = 4'd0;
        bus.Load_data     = 8'h00;
        bus.Start         = 1'b0;
        bus4.Load_enable  = 1'b0;
        bus4.Load_address = 2'd0;
        bus4.Load_data    = 8'h00;
        bus4.Start        = 1'b0;

        // Expected per-slot view of program 24,48,E0; a load of mem[1]=FF is tried while running.
        vecs[0] = '{"slot1_add", 3'b001, 3'b001, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 4'd1, 8'hFF};
        vecs[1] = '{"slot2_sub", 3'b010, 3'b010, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00};
        vecs[2] = '{"slot3_hlt", 3'b111, 3'b000, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00};
        wrap_pc[0] = 2'd1; wrap_pc[1] = 2'd2; wrap_pc[2] = 2'd3; wrap_pc[3] = 2'd0; wrap_pc[4] = 2'd1;
        wrap_a1[0] = 3'd1; wrap_a1[1] = 3'd2; wrap_a1[2] = 3'd3; wrap_a1[3] = 3'd4; wrap_a1[4] = 3'd1;

        // Reset values.
        repeat (3) tick();
        chk("rst_opcode", bus.Opcode, 3'b111);
        chk("rst_op1",    bus.Operand_1_address, 3'b000);
        chk("rst_slot",   bus.Slot, 3'd0);
        chk("rst_pc",     bus.PC_out, 4'd0);
        chk("rst_run",    bus.Running, 1'b0);
        chk("rst_halt",   bus.Halted, 1'b0);
        RESET = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("slot_count_%0d", k), bus.Slot, k % 8);
        end

        // Load and run.
        load(4'd0, 8'h24);
        load(4'd1, 8'h48);
        load(4'd2, 8'hE0);
        wait_slot(3'd3);
        pulse_start();
        chk("start_wait_idle", bus.Running, 1'b0);
        wait_slot(3'd0);
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("%s_c%0d_slot", vecs[i].name, c), bus.Slot, c);
                chk($sformatf("%s_c%0d_op1", vecs[i].name, c), bus.Operand_1_address, vecs[i].a1);
                chk($sformatf("%s_c%0d_o2t", vecs[i].name, c), bus.Operand_2_type, vecs[i].o2t);
                chk($sformatf("%s_c%0d_onum", vecs[i].name, c), bus.Operand_number, vecs[i].onum);
                chk_status($sformatf("%s_c%0d", vecs[i].name, c),
                           vecs[i].op, vecs[i].pc, vecs[i].run, vecs[i].halt);
                if (c == 2 && vecs[i].ld_en) begin
                    bus.Load_enable  = 1'b1;
                    bus.Load_address = vecs[i].ld_addr;
                    bus.Load_data    = vecs[i].ld_data;
                end
                if (c == 3) begin
                    bus.Load_enable = 1'b0;
                end
                tick();
            end
        end

        // Restart after HALT with Start at Slot 7: accepted on that edge.
        wait_slot(3'd7);
        pulse_start();
        chk("restart_slot", bus.Slot, 3'd0);
        chk_status("restart", 3'b001, 4'd1, 1'b1, 1'b0);

        // Reset at Slot 4 of the second instruction.
        tick();
        wait_slot(3'd0);
        wait_slot(3'd4);
        chk("midrun_pre_opcode", bus.Opcode, 3'b010);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrun_rst_slot", bus.Slot, 3'd0);
        chk("midrun_rst_op1",  bus.Operand_1_address, 3'b000);
        chk("midrun_rst_o2t",  bus.Operand_2_type, 1'b0);
        chk("midrun_rst_onum", bus.Operand_number, 1'b0);
        chk_status("midrun_rst", 3'b111, 4'd0, 1'b0, 1'b0);

        // Later Start restarts at address 0; a Start while running is ignored.
        wait_slot(3'd2);
        pulse_start();
        wait_slot(3'd0);
        chk_status("rerun", 3'b001, 4'd1, 1'b1, 1'b0);
        wait_slot(3'd5);
        pulse_start();
        wait_slot(3'd0);
        chk_status("rerun_2nd", 3'b010, 4'd2, 1'b1, 1'b0);
        repeat (8) tick();
        chk_status("rerun_hlt", 3'b111, 4'd2, 1'b0, 1'b1);
        repeat (16) tick();
        chk_status("run_start_ignored", 3'b111, 4'd2, 1'b0, 1'b1);

        // Reset discards a pending Start.
        wait_slot(3'd1);
        pulse_start();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (12) tick();
        chk_status("pending_discard", 3'b111, 4'd0, 1'b0, 1'b0);

        // Reset and Start together: reset wins.
        wait_slot(3'd6);
        RESET     = 1'b1;
        bus.Start = 1'b1;
        tick();
        RESET     = 1'b0;
        bus.Start = 1'b0;
        chk("rst_start_slot", bus.Slot, 3'd0);
        repeat (12) tick();
        chk_status("rst_start_idle", 3'b111, 4'd0, 1'b0, 1'b0);

        // HLT at address 0; a same-edge load of address 0 is not seen by the fetch.
        load(4'd0, 8'hE3);
        wait_slot(3'd7);
        bus.Start        = 1'b1;
        bus.Load_enable  = 1'b1;
        bus.Load_address = 4'd0;
        bus.Load_data    = 8'h24;
        tick();
        bus.Start       = 1'b0;
        bus.Load_enable = 1'b0;
        chk("hlt0_o2t",  bus.Operand_2_type, 1'b1);
        chk("hlt0_onum", bus.Operand_number, 1'b1);
        chk_status("hlt0", 3'b111, 4'd0, 1'b0, 1'b1);
        wait_slot(3'd7);
        pulse_start();
        chk_status("hlt0_restart", 3'b001, 4'd1, 1'b1, 1'b0);

        // PC wrap on the 4-word unit with no HLT in the program.
        load4(2'd0, 8'h04);
        load4(2'd1, 8'h08);
        load4(2'd2, 8'h0C);
        load4(2'd3, 8'h10);
        wait_slot(3'd0);
        bus4.Start = 1'b1;
        tick();
        bus4.Start = 1'b0;
        wait_slot(3'd0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wrap_%0d_pc", k),  bus4.PC_out, wrap_pc[k]);
            chk($sformatf("wrap_%0d_op1", k), bus4.Operand_1_address, wrap_a1[k]);
            chk($sformatf("wrap_%0d_run", k), bus4.Running, 1'b1);
            repeat (8) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
